// File: rtl/game_tick_scheduler.sv
// Frame-locked game update scheduler: one start/done handshake every div_sel frames, with overrun flagging.
// Optional feature macro SCHED_OVR_CNT_EN: when defined, ovr_count is a saturating counter; otherwise it is tied to 0.
module game_tick_scheduler #(
  parameter int FRAMES_W = 4,
  parameter int OVR_W    = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                vblank,
  input  logic                pause,
  input  logic [FRAMES_W-1:0] div_sel,
  input  logic                upd_done,
  input  logic                clr_ovr,
  output logic                upd_start,
  output logic                busy,
  output logic                was_updated,
  output logic [FRAMES_W-1:0] frames_passed,
  output logic                overrun,
  output logic [OVR_W-1:0]    ovr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [FRAMES_W:0] ONE_WIDE = {{FRAMES_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic              pending_r;
  logic              pending_nxt_s;
  logic              vblank_d_r;
  logic              frame_edge_s;
  logic              vblank_end_s;
  logic              tick_due_s;
  logic              done_acc_s;
  logic              ovr_evt_s;
  logic [FRAMES_W:0] div_eff_s;
  logic [FRAMES_W:0] fp_inc_s;

  assign frame_edge_s = vblank & ~vblank_d_r;
  assign vblank_end_s = ~vblank & vblank_d_r;
  // Extra bit on the compare keeps frames_passed+1 from wrapping.
  assign div_eff_s    = (div_sel == {FRAMES_W{1'b0}}) ? ONE_WIDE : {1'b0, div_sel};
  assign fp_inc_s     = {1'b0, frames_passed} + ONE_WIDE;
  assign tick_due_s   = frame_edge_s & ~pause & (fp_inc_s >= div_eff_s);
  assign done_acc_s   = (state_r == WAIT) & upd_done;
  assign ovr_evt_s    = vblank_end_s & (state_r == WAIT) & ~upd_done;

  assign upd_start = (state_r == START);
  assign busy      = (state_r == START) || (state_r == WAIT);

  // Next-state and pending-tick logic; ticks arriving while busy collapse into one pending.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    case (state_r)
      IDLE: begin
        if (tick_due_s || pending_r) begin
          state_nxt_s   = START;
          pending_nxt_s = 1'b0;
        end else begin
          state_nxt_s   = IDLE;
          pending_nxt_s = pending_r;
        end
      end
      START: begin
        state_nxt_s = WAIT;
        if (tick_due_s) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      WAIT: begin
        if (upd_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
        if (tick_due_s) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State, edge-detect and frame counter registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r       <= IDLE;
      pending_r     <= 1'b0;
      vblank_d_r    <= 1'b0;
      frames_passed <= {FRAMES_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      pending_r  <= pending_nxt_s;
      vblank_d_r <= vblank;
      if (frame_edge_s && !pause) begin
        if (tick_due_s) begin
          frames_passed <= {FRAMES_W{1'b0}};
        end else begin
          frames_passed <= fp_inc_s[FRAMES_W-1:0];
        end
      end
    end
  end

  // Completion flag and sticky overrun; a fresh overrun event beats a simultaneous clear.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      was_updated <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (done_acc_s) begin
        was_updated <= 1'b1;
      end else if (frame_edge_s) begin
        was_updated <= 1'b0;
      end
      if (ovr_evt_s) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SCHED_OVR_CNT_EN
  localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};
  localparam logic [OVR_W-1:0] OVR_ONE = {{(OVR_W-1){1'b0}}, 1'b1};

  // Saturating overrun event counter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ovr_count <= {OVR_W{1'b0}};
    end else if (ovr_evt_s) begin
      if (clr_ovr) begin
        ovr_count <= OVR_ONE;
      end else if (ovr_count == OVR_MAX) begin
        ovr_count <= OVR_MAX;
      end else begin
        ovr_count <= ovr_count + OVR_ONE;
      end
    end else if (clr_ovr) begin
      ovr_count <= {OVR_W{1'b0}};
    end
  end
`else
  assign ovr_count = {OVR_W{1'b0}};
`endif

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler: a frame-level reference model pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_game_tick_scheduler;

  logic       sys_clk;
  logic       sys_rst;
  logic       vblank;
  logic       pause;
  logic [3:0] div_sel;
  logic       upd_done;
  logic       clr_ovr;
  logic       upd_start;
  logic       busy;
  logic       was_updated;
  logic [3:0] frames_passed;
  logic       overrun;
  logic [7:0] ovr_count;

  game_tick_scheduler #(.FRAMES_W(4), .OVR_W(8)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .vblank       (vblank),
    .pause        (pause),
    .div_sel      (div_sel),
    .upd_done     (upd_done),
    .clr_ovr      (clr_ovr),
    .upd_start    (upd_start),
    .busy         (busy),
    .was_updated  (was_updated),
    .frames_passed(frames_passed),
    .overrun      (overrun),
    .ovr_count    (ovr_count)
  );

  typedef struct {
    bit start;
    bit bsy;
    bit was;
    bit ovr;
    int fp;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: update outstanding, start pulse visible, one pending tick, counters.
  bit m_vbd, m_start, m_busy, m_pend, m_was, m_ovr;
  int m_fp, m_cnt;

  // Emulated game_logic: countdown to upd_done after each start.
  int done_cnt  = 0;
  int cur_dly   = 5;
  bit dly_rand  = 0;
  bit done_hold = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("upd_start", int'(upd_start), int'(mon_e.start));
      chk("busy", int'(busy), int'(mon_e.bsy));
      chk("was_updated", int'(was_updated), int'(mon_e.was));
      chk("frames_passed", int'(frames_passed), mon_e.fp);
      chk("overrun", int'(overrun), int'(mon_e.ovr));
`ifdef SCHED_OVR_CNT_EN
      chk("ovr_count", int'(ovr_count), mon_e.cnt);
`else
      chk("ovr_count", int'(ovr_count), 0);
`endif
    end
  end

  task automatic model_reset();
    m_vbd = 0; m_start = 0; m_busy = 0; m_pend = 0; m_was = 0; m_ovr = 0;
    m_fp = 0; m_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.start = m_start; e.bsy = m_busy; e.was = m_was; e.ovr = m_ovr;
    e.fp = m_fp; e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic step(input bit vb, input bit pz, input logic [3:0] ds, input bit clr,
                      input bit fdone, input bit spur);
    bit d, edge_s, vend, tick, waiting, accept, ovr_ev, nstart;
    int de;
    push_exp();
    d = 0;
    if (fdone) begin
      d = 1; done_cnt = 0;
    end else if (done_cnt == 1) begin
      if (!done_hold) begin
        d = 1; done_cnt = 0;
      end
    end else if (done_cnt > 1) begin
      done_cnt--;
    end
    if (spur && !m_busy && ($urandom % 16 == 0)) d = 1;
    if (m_start) done_cnt = dly_rand ? int'($urandom_range(1, 20)) : cur_dly;

    vblank = vb; pause = pz; div_sel = ds; clr_ovr = clr; upd_done = d;

    edge_s  = vb && !m_vbd;
    vend    = !vb && m_vbd;
    de      = (ds == 0) ? 1 : int'(ds);
    tick    = edge_s && !pz && (m_fp + 1 >= de);
    waiting = m_busy && !m_start;
    accept  = waiting && d;
    ovr_ev  = vend && waiting && !d;
    nstart  = !m_busy && (tick || m_pend);
    if (m_busy) m_pend = m_pend || tick;
    else m_pend = 0;
    m_busy  = nstart || (m_busy && !accept);
    m_start = nstart;
    if (edge_s && !pz) m_fp = tick ? 0 : m_fp + 1;
    if (accept) m_was = 1;
    else if (edge_s) m_was = 0;
    if (ovr_ev) begin
      m_ovr = 1;
      m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_ovr = 0; m_cnt = 0;
    end
    m_vbd = vb;

    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1; vblank = 0; pause = 0; upd_done = 0; clr_ovr = 0;
    model_reset();
    #1;
    chk("rst_upd_start", int'(upd_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_was_updated", int'(was_updated), 0);
    chk("rst_frames_passed", int'(frames_passed), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ovr_count", int'(ovr_count), 0);
    repeat (n) begin
      push_exp();
      @(posedge sys_clk);
      #1;
    end
    sys_rst = 0;
  endtask

  task automatic frame(input int vbl, input int act, input bit pz, input logic [3:0] ds,
                       input bit clr_fall, input bit done_fall, input bit rnd);
    for (int i = 0; i < vbl; i++)
      step(1'b1, pz, ds, rnd && ($urandom % 25 == 0), 1'b0, rnd);
    for (int i = 0; i < act; i++)
      step(1'b0, pz, ds, (clr_fall && i == 0) || (rnd && ($urandom % 25 == 0)),
           done_fall && i == 0, rnd);
  endtask

  initial begin
    logic [3:0] rds;
    sys_rst = 1; vblank = 0; pause = 0; div_sel = 4'd0; upd_done = 0; clr_ovr = 0;
    model_reset();
    @(posedge sys_clk);
    #1;
    do_reset(3);

    // Frame divide by 3, update completes after 5 cycles.
    repeat (4) step(1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    cur_dly = 5;
    repeat (9) frame(3, 10, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);

    // Reset while an update is in flight during vblank.
    step(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    repeat (6) step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    frame(3, 8, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);

    // Done withheld until two cycles past the vblank fall, then cleared.
    done_hold = 1;
    frame(3, 2, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    done_hold = 0;
    repeat (4) step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);

    // Done withheld across two further frame starts: one pending tick survives.
    done_hold = 1;
    repeat (3) frame(3, 6, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    done_hold = 0;
    repeat (12) step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);

    // Pause for four frames, then release with div_sel=0.
    frame(3, 8, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    repeat (4) frame(3, 8, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    repeat (4) frame(3, 8, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Done coincident with vblank fall is on time.
    cur_dly = 30;
    done_hold = 1;
    frame(3, 0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    done_hold = 0;
    frame(0, 6, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    // Clear coincident with a second overrun event.
    done_hold = 1;
    frame(3, 4, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    frame(3, 0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    frame(0, 3, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    done_hold = 0;
    cur_dly = 3;
    repeat (10) step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);

    // Long stall drives the overrun counter into saturation.
    done_hold = 1;
    repeat (260) frame(2, 3, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    done_hold = 0;
    frame(3, 10, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);

    // Randomized frames, divisors, pauses, clears and update lengths.
    dly_rand = 1;
    rds = 4'd2;
    repeat (300) begin
      if ($urandom % 6 == 0) rds = 4'($urandom_range(0, 5));
      frame(int'($urandom_range(2, 6)), int'($urandom_range(3, 16)), ($urandom % 8 == 0),
            rds, 1'b0, 1'b0, 1'b1);
    end
    repeat (25) step(1'b0, 1'b0, rds, 1'b0, 1'b0, 1'b0);

    @(posedge sys_clk);
    @(posedge sys_clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
